reservation_station: RTL and testbench
======================================

# reservation_station

Unified out-of-order reservation station sitting between rename/dispatch and the execution units (add, load, mul, div). It buffers up to 32 dispatched instructions and captures pending source operands from four result broadcast buses. It issues one ready instruction per cycle, oldest first, to the execute stage. It also supports store ordering and branch-misprediction flush.

## Interface
- Parameters: none. Constants: DEPTH = 32 entries; entry index is 5 bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rs_on  in  1  dispatch valid
- stall  in  1  freezes dispatch and issue
- mem_write  in  1  dispatched instruction is a store
- alu_done_{add,load,mul,div}  in  1  broadcast valid, one per bus
- alu_result_{add,load,mul,div}  in  32  result value, one per bus
- alu_phy_reg_{add,load,mul,div}  in  7  destination physical tag, one per bus
- alu_rs_add_{add,load,mul,div}  in  7  completing entry index (low 5 bits used), one per bus
- in_branch_flag  in  1  instruction is a branch
- in_rd_phy  in  7  destination physical reg
- in_rd_reg  in  5  destination architectural reg
- in_done  in  1  already complete, so do not allocate
- in_ready  in  2  [0] op1 ready, [1] op2 ready
- in_opcode  in  7  opcode
- in_func3  in  3  func3
- in_control  in  10  control bits
- in_operand1, in_operand2  in  32  operand values (valid when ready)
- in_phy_add1, in_phy_add2  in  7  source tags
- in_pc  in  10  PC
- in_label  in  32  branch target/immediate
- branch_rs_add  in  7  mispredicted branch entry index
- branch_in  in  1  flush request
- out_rs_add  out  5  issued entry index
- out_rd_phy, out_rd_reg, out_operand1, out_operand2, out_opcode, out_func3, out_control, out_pc, out_label, out_branch_flag  out  (widths as inputs)  issued payload
- out_execute_on  out  1  issue valid pulse

## Operation
- Entry fields: valid, issued, rdy1, rdy2, tag1, tag2, op1, op2, full payload, store bit.
- Allocation: when rs_on & !stall & !in_done and the station is not full, write the entry at the tail pointer and increment tail (mod 32). Entries are ordered circularly from head to tail.
- Dispatch bypass: if a source tag matches a same-cycle valid broadcast, the operand is written as ready with the broadcast value.
- Wakeup: for every valid, not-ready source, a tag match on any asserted alu_done_* bus captures that bus's result and sets ready. All four buses are checked in parallel. If several buses match the same tag, the lowest-numbered bus wins (add, load, mul, div).
- Issue select: the oldest valid, not-issued entry with rdy1 & rdy2. A store entry is eligible only when it is the head. The selected entry sets issued and drives out_* with out_execute_on = 1.
- Release: an alu_done_* bus with alu_rs_add_* pointing at a valid entry clears valid. The head advances past invalid entries.
- Flush: branch_in invalidates all entries strictly younger than branch_rs_add and sets tail = branch_rs_add + 1. Flush overrides same-cycle allocation.
- Full (32 valid): rs_on is ignored. Upstream must stall.

## Timing
- Reset (rst = 0): all entries invalid, head = tail = 0, all out_* = 0, out_execute_on = 0.
- Dispatch at edge N. The entry is issuable at edge N+1 at the earliest, and out_* is registered and visible after edge N+1.
- Broadcast sampled at edge N. The woken entry is issuable at edge N+1.
- out_execute_on is a single-cycle pulse per issue and is 0 in cycles with no issue.
- stall = 1: no allocation, no issue, out_execute_on = 0. Wakeup, release and flush still act.
- Simultaneous allocate, wakeup and release on different entries all take effect at the same edge.

## Structure
- Shared package: DEPTH, tag width (7), opcode constants (R-type 0110011, load 0000011, store, branch), and the entry struct.
- A natural sub-module is rs_entry_wakeup: a per-entry comparator of tag against the four buses, with priority mux.

## Test plan
- Reset, then dispatch ADD (in_ready = 11, op1 = 2, op2 = 3, rd_phy = 1) -> next cycle out_execute_on = 1, out_rs_add = 0, operands 2 and 3.
- Dispatch MUL (rd_phy = 5, tag1 = 1, in_ready = 10) while the add bus broadcasts tag 1 = 5 -> MUL issues with op1 = 5, op2 = 3.
- Dispatch SUB (tag1 = 5, pending) -> no issue until the mul bus broadcasts tag 5 = 15; the issue cycle after that shows op1 = 15.
- Simultaneous add-bus tag 7 = 12 and mul-bus tag 5 = 15 -> both dependent entries wake; the older one issues first, the other on the next cycle.
- Store at a non-head position with operands ready -> held until the older entries are released, then issues.
- Four entries, then branch_in with branch_rs_add = 1 -> entries 2 and 3 are never issued, and the next dispatch lands in entry 2.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared constants, opcode encodings and the entry record for the reservation station.
package reservation_station_pkg;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned TAG_W   = 7;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_BUS = 4;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic              valid;
        logic              issued;
        logic              rdy1;
        logic              rdy2;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic              store;
        logic              branch_flag;
        logic [6:0]        rd_phy;
        logic [4:0]        rd_reg;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [9:0]        control;
        logic [9:0]        pc;
        logic [31:0]       label;
    } rs_entry_t;

    // Position of an entry in program order, counted from the head.
    function automatic logic [IDX_W-1:0] rs_age(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/reservation_station_wakeup.sv
// Compares one source tag against the four result buses; lowest-numbered bus wins.
module reservation_station_wakeup
    import reservation_station_pkg::*;
(
    input  logic [TAG_W-1:0]                tag_i,
    input  logic [NUM_BUS-1:0]              done_i,
    input  logic [NUM_BUS-1:0][TAG_W-1:0]   bus_tag_i,
    input  logic [NUM_BUS-1:0][DATA_W-1:0]  bus_data_i,
    output logic                            hit_o,
    output logic [DATA_W-1:0]               data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        // Walk from the highest bus down so the lowest matching bus is written last.
        for (int b = NUM_BUS - 1; b >= 0; b--) begin
            if (done_i[b] && (bus_tag_i[b] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = bus_data_i[b];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// 32-entry unified reservation station: dispatch, operand wakeup, oldest-first issue,
// in-order stores, release and branch flush.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rs_on,
    input  logic        stall,
    input  logic        mem_write,
    input  logic        alu_done_add,
    input  logic        alu_done_load,
    input  logic        alu_done_mul,
    input  logic        alu_done_div,
    input  logic [31:0] alu_result_add,
    input  logic [31:0] alu_result_load,
    input  logic [31:0] alu_result_mul,
    input  logic [31:0] alu_result_div,
    input  logic [6:0]  alu_phy_reg_add,
    input  logic [6:0]  alu_phy_reg_load,
    input  logic [6:0]  alu_phy_reg_mul,
    input  logic [6:0]  alu_phy_reg_div,
    input  logic [6:0]  alu_rs_add_add,
    input  logic [6:0]  alu_rs_add_load,
    input  logic [6:0]  alu_rs_add_mul,
    input  logic [6:0]  alu_rs_add_div,
    input  logic        in_branch_flag,
    input  logic [6:0]  in_rd_phy,
    input  logic [4:0]  in_rd_reg,
    input  logic        in_done,
    input  logic [1:0]  in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_func3,
    input  logic [9:0]  in_control,
    input  logic [31:0] in_operand1,
    input  logic [31:0] in_operand2,
    input  logic [6:0]  in_phy_add1,
    input  logic [6:0]  in_phy_add2,
    input  logic [9:0]  in_pc,
    input  logic [31:0] in_label,
    input  logic [6:0]  branch_rs_add,
    input  logic        branch_in,
    output logic [4:0]  out_rs_add,
    output logic [6:0]  out_rd_phy,
    output logic [4:0]  out_rd_reg,
    output logic [31:0] out_operand1,
    output logic [31:0] out_operand2,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_func3,
    output logic [9:0]  out_control,
    output logic [9:0]  out_pc,
    output logic [31:0] out_label,
    output logic        out_branch_flag,
    output logic        out_execute_on
);

    logic [NUM_BUS-1:0]             bus_done;
    logic [NUM_BUS-1:0][TAG_W-1:0]  bus_tag;
    logic [NUM_BUS-1:0][DATA_W-1:0] bus_data;
    logic [NUM_BUS-1:0][IDX_W-1:0]  bus_rs;
    logic [IDX_W-1:0]               br_idx;
    logic                           unused_idx_hi;

    assign bus_done = {alu_done_div, alu_done_mul, alu_done_load, alu_done_add};
    assign bus_tag  = {alu_phy_reg_div, alu_phy_reg_mul, alu_phy_reg_load, alu_phy_reg_add};
    assign bus_data = {alu_result_div, alu_result_mul, alu_result_load, alu_result_add};
    assign bus_rs   = {alu_rs_add_div[4:0], alu_rs_add_mul[4:0], alu_rs_add_load[4:0],
                       alu_rs_add_add[4:0]};
    assign br_idx   = branch_rs_add[4:0];
    assign unused_idx_hi = ^{alu_rs_add_div[6:5], alu_rs_add_mul[6:5], alu_rs_add_load[6:5],
                             alu_rs_add_add[6:5], branch_rs_add[6:5]};

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        new_e;
    logic [IDX_W-1:0] head_q, tail_q, tail_d, head_eff, sel_idx;
    logic [DEPTH-1:0] hit1, hit2, kill;
    logic [DATA_W-1:0] data1 [DEPTH];
    logic [DATA_W-1:0] data2 [DEPTH];
    logic             byp1_hit, byp2_hit, sel_found, do_issue, do_alloc;
    logic [DATA_W-1:0] byp1_data, byp2_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        reservation_station_wakeup u_wake1 (
            .tag_i(ent_q[i].tag1), .done_i(bus_done), .bus_tag_i(bus_tag),
            .bus_data_i(bus_data), .hit_o(hit1[i]), .data_o(data1[i])
        );
        reservation_station_wakeup u_wake2 (
            .tag_i(ent_q[i].tag2), .done_i(bus_done), .bus_tag_i(bus_tag),
            .bus_data_i(bus_data), .hit_o(hit2[i]), .data_o(data2[i])
        );
    end

    reservation_station_wakeup u_byp1 (
        .tag_i(in_phy_add1), .done_i(bus_done), .bus_tag_i(bus_tag),
        .bus_data_i(bus_data), .hit_o(byp1_hit), .data_o(byp1_data)
    );
    reservation_station_wakeup u_byp2 (
        .tag_i(in_phy_add2), .done_i(bus_done), .bus_tag_i(bus_tag),
        .bus_data_i(bus_data), .hit_o(byp2_hit), .data_o(byp2_data)
    );

    // Effective head: first live entry at or after head_q, or tail when the ring is empty.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             hdone;
        idx      = '0;
        hdone    = 1'b0;
        head_eff = tail_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + IDX_W'(k);
            if (!hdone) begin
                if (ent_q[idx].valid) begin
                    head_eff = idx;
                    hdone    = 1'b1;
                end else if (idx == tail_q) begin
                    hdone = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill[i] = branch_in && ent_q[i].valid &&
                      (rs_age(IDX_W'(i), head_eff) > rs_age(br_idx, head_eff));
        end
    end

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_eff + IDX_W'(k);
            if (!sel_found && ent_q[idx].valid && !ent_q[idx].issued && ent_q[idx].rdy1 &&
                ent_q[idx].rdy2 && !kill[idx] && (!ent_q[idx].store || idx == head_eff)) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    assign do_issue = sel_found && !stall;
    assign do_alloc = rs_on && !stall && !in_done && !ent_q[tail_q].valid && !branch_in;

    always_comb begin
        new_e             = '0;
        new_e.valid       = 1'b1;
        new_e.rdy1        = in_ready[0] | byp1_hit;
        new_e.rdy2        = in_ready[1] | byp2_hit;
        new_e.op1         = in_ready[0] ? in_operand1 : byp1_data;
        new_e.op2         = in_ready[1] ? in_operand2 : byp2_data;
        new_e.tag1        = in_phy_add1;
        new_e.tag2        = in_phy_add2;
        new_e.store       = mem_write;
        new_e.branch_flag = in_branch_flag;
        new_e.rd_phy      = in_rd_phy;
        new_e.rd_reg      = in_rd_reg;
        new_e.opcode      = in_opcode;
        new_e.func3       = in_func3;
        new_e.control     = in_control;
        new_e.pc          = in_pc;
        new_e.label       = in_label;
    end

    always_comb begin
        ent_d  = ent_q;
        tail_d = tail_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].rdy1 && hit1[i]) begin
                ent_d[i].rdy1 = 1'b1;
                ent_d[i].op1  = data1[i];
            end
            if (ent_q[i].valid && !ent_q[i].rdy2 && hit2[i]) begin
                ent_d[i].rdy2 = 1'b1;
                ent_d[i].op2  = data2[i];
            end
            for (int unsigned b = 0; b < NUM_BUS; b++) begin
                if (bus_done[b] && bus_rs[b] == IDX_W'(i)) ent_d[i].valid = 1'b0;
            end
            if (kill[i]) ent_d[i].valid = 1'b0;
        end
        if (do_issue) ent_d[sel_idx].issued = 1'b1;
        if (branch_in) tail_d = br_idx + 1'b1;
        if (do_alloc) begin
            ent_d[tail_q] = new_e;
            tail_d        = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_eff;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_rs_add      <= '0;
            out_rd_phy      <= '0;
            out_rd_reg      <= '0;
            out_operand1    <= '0;
            out_operand2    <= '0;
            out_opcode      <= '0;
            out_func3       <= '0;
            out_control     <= '0;
            out_pc          <= '0;
            out_label       <= '0;
            out_branch_flag <= 1'b0;
            out_execute_on  <= 1'b0;
        end else begin
            out_execute_on <= do_issue;
            if (do_issue) begin
                out_rs_add      <= sel_idx;
                out_rd_phy      <= ent_q[sel_idx].rd_phy;
                out_rd_reg      <= ent_q[sel_idx].rd_reg;
                out_operand1    <= ent_q[sel_idx].op1;
                out_operand2    <= ent_q[sel_idx].op2;
                out_opcode      <= ent_q[sel_idx].opcode;
                out_func3       <= ent_q[sel_idx].func3;
                out_control     <= ent_q[sel_idx].control;
                out_pc          <= ent_q[sel_idx].pc;
                out_label       <= ent_q[sel_idx].label;
                out_branch_flag <= ent_q[sel_idx].branch_flag;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, bypass, wakeup, store ordering, flush.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rs_on, stall, mem_write;
    logic        alu_done_add, alu_done_load, alu_done_mul, alu_done_div;
    logic [31:0] alu_result_add, alu_result_load, alu_result_mul, alu_result_div;
    logic [6:0]  alu_phy_reg_add, alu_phy_reg_load, alu_phy_reg_mul, alu_phy_reg_div;
    logic [6:0]  alu_rs_add_add, alu_rs_add_load, alu_rs_add_mul, alu_rs_add_div;
    logic        in_branch_flag, in_done, branch_in;
    logic [6:0]  in_rd_phy, in_opcode, in_phy_add1, in_phy_add2, branch_rs_add;
    logic [4:0]  in_rd_reg;
    logic [1:0]  in_ready;
    logic [2:0]  in_func3;
    logic [9:0]  in_control, in_pc;
    logic [31:0] in_operand1, in_operand2, in_label;
    logic [4:0]  out_rs_add, out_rd_reg;
    logic [6:0]  out_rd_phy, out_opcode;
    logic [31:0] out_operand1, out_operand2, out_label;
    logic [2:0]  out_func3;
    logic [9:0]  out_control, out_pc;
    logic        out_branch_flag, out_execute_on;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rs_on(rs_on), .stall(stall), .mem_write(mem_write),
        .alu_done_add(alu_done_add), .alu_done_load(alu_done_load),
        .alu_done_mul(alu_done_mul), .alu_done_div(alu_done_div),
        .alu_result_add(alu_result_add), .alu_result_load(alu_result_load),
        .alu_result_mul(alu_result_mul), .alu_result_div(alu_result_div),
        .alu_phy_reg_add(alu_phy_reg_add), .alu_phy_reg_load(alu_phy_reg_load),
        .alu_phy_reg_mul(alu_phy_reg_mul), .alu_phy_reg_div(alu_phy_reg_div),
        .alu_rs_add_add(alu_rs_add_add), .alu_rs_add_load(alu_rs_add_load),
        .alu_rs_add_mul(alu_rs_add_mul), .alu_rs_add_div(alu_rs_add_div),
        .in_branch_flag(in_branch_flag), .in_rd_phy(in_rd_phy), .in_rd_reg(in_rd_reg),
        .in_done(in_done), .in_ready(in_ready), .in_opcode(in_opcode), .in_func3(in_func3),
        .in_control(in_control), .in_operand1(in_operand1), .in_operand2(in_operand2),
        .in_phy_add1(in_phy_add1), .in_phy_add2(in_phy_add2), .in_pc(in_pc),
        .in_label(in_label), .branch_rs_add(branch_rs_add), .branch_in(branch_in),
        .out_rs_add(out_rs_add), .out_rd_phy(out_rd_phy), .out_rd_reg(out_rd_reg),
        .out_operand1(out_operand1), .out_operand2(out_operand2), .out_opcode(out_opcode),
        .out_func3(out_func3), .out_control(out_control), .out_pc(out_pc),
        .out_label(out_label), .out_branch_flag(out_branch_flag),
        .out_execute_on(out_execute_on)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_on = 0; stall = 0; mem_write = 0; in_done = 0; branch_in = 0; branch_rs_add = 0;
        alu_done_add = 0; alu_done_load = 0; alu_done_mul = 0; alu_done_div = 0;
        alu_result_add = 0; alu_result_load = 0; alu_result_mul = 0; alu_result_div = 0;
        alu_phy_reg_add = 0; alu_phy_reg_load = 0; alu_phy_reg_mul = 0; alu_phy_reg_div = 0;
        alu_rs_add_add = 0; alu_rs_add_load = 0; alu_rs_add_mul = 0; alu_rs_add_div = 0;
        in_branch_flag = 0; in_rd_phy = 0; in_rd_reg = 0; in_ready = 0; in_opcode = 0;
        in_func3 = 0; in_control = 0; in_operand1 = 0; in_operand2 = 0;
        in_phy_add1 = 0; in_phy_add2 = 0; in_pc = 0; in_label = 0;
    endtask

    task automatic dispatch(input logic [6:0] rd, input logic [1:0] rdy, input logic [31:0] a,
                            input logic [31:0] b, input logic [6:0] t1, input logic st,
                            input logic br);
        rs_on = 1; in_rd_phy = rd; in_ready = rdy; in_operand1 = a; in_operand2 = b;
        in_phy_add1 = t1; in_phy_add2 = 7'd0; mem_write = st; in_branch_flag = br;
        in_opcode = st ? OP_STORE : (br ? OP_BRANCH : OP_RTYPE);
        in_pc = 10'(rd) + 10'd100;
    endtask

    // b: 0 add, 1 load, 2 mul, 3 div
    task automatic bus(input int b, input logic [6:0] tag, input logic [31:0] data,
                       input logic [6:0] rs);
        case (b)
            0: begin alu_done_add = 1; alu_phy_reg_add = tag; alu_result_add = data;
                     alu_rs_add_add = rs; end
            1: begin alu_done_load = 1; alu_phy_reg_load = tag; alu_result_load = data;
                     alu_rs_add_load = rs; end
            2: begin alu_done_mul = 1; alu_phy_reg_mul = tag; alu_result_mul = data;
                     alu_rs_add_mul = rs; end
            default: begin alu_done_div = 1; alu_phy_reg_div = tag; alu_result_div = data;
                     alu_rs_add_div = rs; end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        repeat (3) tick();
        check("reset_exec", 32'(out_execute_on), 0);
        check("reset_rs_add", 32'(out_rs_add), 0);
        check("reset_op1", out_operand1, 0);
        check("reset_rd_phy", 32'(out_rd_phy), 0);
        rst = 1;

        // ADD, both operands ready
        dispatch(7'd1, 2'b11, 32'd2, 32'd3, 7'd0, 0, 0);
        tick();
        check("add_dispatch_no_issue", 32'(out_execute_on), 0);
        clear_inputs();
        tick();
        check("add_exec", 32'(out_execute_on), 1);
        check("add_rs_add", 32'(out_rs_add), 0);
        check("add_op1", out_operand1, 2);
        check("add_op2", out_operand2, 3);
        check("add_rd_phy", 32'(out_rd_phy), 1);

        // MUL with same-cycle bypass of tag 1 = 5; add bus also releases entry 0
        dispatch(7'd5, 2'b10, 32'd0, 32'd3, 7'd1, 0, 0);
        bus(0, 7'd1, 32'd5, 7'd0);
        tick();
        check("mul_dispatch_no_issue", 32'(out_execute_on), 0);
        clear_inputs();
        tick();
        check("mul_exec", 32'(out_execute_on), 1);
        check("mul_rs_add", 32'(out_rs_add), 1);
        check("mul_op1", out_operand1, 5);
        check("mul_op2", out_operand2, 3);

        // SUB waiting on tag 5
        dispatch(7'd7, 2'b10, 32'd0, 32'd4, 7'd5, 0, 0);
        tick();
        clear_inputs();
        tick();
        check("sub_pending", 32'(out_execute_on), 0);
        bus(2, 7'd5, 32'd15, 7'd1);
        tick();
        clear_inputs();
        check("sub_wake_edge", 32'(out_execute_on), 0);
        tick();
        check("sub_exec", 32'(out_execute_on), 1);
        check("sub_rs_add", 32'(out_rs_add), 2);
        check("sub_op1", out_operand1, 15);
        check("sub_op2", out_operand2, 4);

        // Two dependents woken on the same edge by different buses
        dispatch(7'd9, 2'b10, 32'd0, 32'd1, 7'd7, 0, 0);
        tick();
        dispatch(7'd10, 2'b10, 32'd0, 32'd2, 7'd5, 0, 0);
        tick();
        clear_inputs();
        bus(0, 7'd7, 32'd12, 7'd2);
        bus(2, 7'd5, 32'd15, 7'd1);
        tick();
        clear_inputs();
        check("dual_wake_edge", 32'(out_execute_on), 0);
        tick();
        check("dual_first_exec", 32'(out_execute_on), 1);
        check("dual_first_rs", 32'(out_rs_add), 3);
        check("dual_first_op1", out_operand1, 12);
        tick();
        check("dual_second_exec", 32'(out_execute_on), 1);
        check("dual_second_rs", 32'(out_rs_add), 4);
        check("dual_second_op1", out_operand1, 15);

        // Store behind entries 3 and 4
        dispatch(7'd0, 2'b11, 32'd100, 32'd200, 7'd0, 1, 0);
        tick();
        clear_inputs();
        check("store_dispatch", 32'(out_execute_on), 0);
        tick();
        check("store_held", 32'(out_execute_on), 0);
        bus(0, 7'd9, 32'd1, 7'd3);
        bus(1, 7'd10, 32'd2, 7'd4);
        tick();
        clear_inputs();
        check("store_release_edge", 32'(out_execute_on), 0);
        tick();
        check("store_exec", 32'(out_execute_on), 1);
        check("store_rs_add", 32'(out_rs_add), 5);
        check("store_op1", out_operand1, 100);
        check("store_op2", out_operand2, 200);
        check("store_opcode", 32'(out_opcode), 32'(OP_STORE));

        // Fresh ring for the flush scenario
        rst = 0;
        #2;
        check("reset2_exec", 32'(out_execute_on), 0);
        check("reset2_rs_add", 32'(out_rs_add), 0);
        rst = 1;
        dispatch(7'd11, 2'b11, 32'd1, 32'd1, 7'd0, 0, 0);
        tick();
        dispatch(7'd12, 2'b11, 32'd2, 32'd2, 7'd0, 0, 1);
        tick();
        check("fl_e0_exec", 32'(out_execute_on), 1);
        check("fl_e0_rs", 32'(out_rs_add), 0);
        dispatch(7'd13, 2'b10, 32'd0, 32'd3, 7'd20, 0, 0);
        tick();
        check("fl_e1_exec", 32'(out_execute_on), 1);
        check("fl_e1_rs", 32'(out_rs_add), 1);
        check("fl_e1_branch", 32'(out_branch_flag), 1);
        check("fl_e1_pc", 32'(out_pc), 112);
        dispatch(7'd14, 2'b10, 32'd0, 32'd4, 7'd20, 0, 0);
        tick();
        check("fl_e3_no_issue", 32'(out_execute_on), 0);
        clear_inputs();
        dispatch(7'd50, 2'b11, 32'd5, 32'd5, 7'd0, 0, 0);
        branch_in = 1;
        branch_rs_add = 7'd1;
        tick();
        clear_inputs();
        check("fl_flush_edge", 32'(out_execute_on), 0);
        bus(0, 7'd20, 32'd77, 7'd31);
        tick();
        clear_inputs();
        check("fl_no_dropped_alloc", 32'(out_execute_on), 0);
        tick();
        check("fl_killed_never_issue", 32'(out_execute_on), 0);
        dispatch(7'd30, 2'b11, 32'd8, 32'd9, 7'd0, 0, 0);
        tick();
        clear_inputs();
        tick();
        check("fl_new_exec", 32'(out_execute_on), 1);
        check("fl_new_rs", 32'(out_rs_add), 2);
        check("fl_new_rd_phy", 32'(out_rd_phy), 30);
        check("fl_new_op1", out_operand1, 8);

        // Stall blocks dispatch; next real dispatch takes entry 3
        dispatch(7'd40, 2'b11, 32'd6, 32'd6, 7'd0, 0, 0);
        stall = 1;
        tick();
        check("stall_exec", 32'(out_execute_on), 0);
        clear_inputs();
        tick();
        check("stall_no_alloc", 32'(out_execute_on), 0);
        dispatch(7'd41, 2'b11, 32'd7, 32'd7, 7'd0, 0, 0);
        tick();
        clear_inputs();
        tick();
        check("post_stall_exec", 32'(out_execute_on), 1);
        check("post_stall_rs", 32'(out_rs_add), 3);
        check("post_stall_rd_phy", 32'(out_rd_phy), 41);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
